// File: rtl/fifo_serial_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fifo_serial_tx_if
// Brief    : Read-port bundle between a FIFO and its single reader.
//            master = the reader (drives Read_enable), slave = the FIFO.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface fifo_serial_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );
endinterface
`default_nettype wire

// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : fifo_serial_tx
// Brief    : Pops words from a FIFO read port and sends each one as a
//            start(0) / LSB-first data / stop(1) frame, BIT_CYCLES clocks
//            per bit, on a registered idle-high serial line.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_serial_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BIT_CYCLES = 4
) (
   input  wire                 clk,
   input  wire                 reset,
   input  wire                 enable,
   fifo_serial_tx_if.master    fifo,
   output logic                tx,
   output logic                busy,
   output logic                frame_done
);

   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_POP   = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;

   logic [2:0]            r_state;
   logic [2:0]            w_state_next;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [IDX_W-1:0]      r_bit_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_tx;

   logic                  w_bit_last;
   logic                  w_idx_last;
   logic                  w_start_ok;
   logic                  w_in_bit_state;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic                  w_tx_next;
   logic                  w_rd_en;
   logic                  w_busy;
   logic                  w_frame_done;

   assign w_bit_last     = (r_bit_cnt == c_BIT_LAST);
   assign w_idx_last     = (r_bit_idx == c_IDX_LAST);
   assign w_start_ok     = enable && !fifo.fifo_empty;
   assign w_in_bit_state = (r_state == S_START) || (r_state == S_DATA) ||
                           (r_state == S_STOP);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decision; enable/empty only matter in IDLE and at STOP exit
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start_ok) w_state_next = S_POP;
         S_POP:   w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_START;
         S_START: if (w_bit_last) w_state_next = S_DATA;
         S_DATA:  if (w_bit_last && w_idx_last) w_state_next = S_STOP;
         S_STOP:  if (w_bit_last) w_state_next = w_start_ok ? S_POP : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      w_rd_en      = (r_state == S_POP);
      w_busy       = (r_state != S_IDLE);
      w_frame_done = (r_state == S_STOP) && w_bit_last;
   end

   // Shift register and line value for the state being entered, so the
   // registered tx changes on the same edge as the state
   always_comb begin
      w_shift_next = r_shift;
      if (r_state == S_LOAD) begin
         w_shift_next = fifo.fifo_data;
      end else if ((r_state == S_DATA) && w_bit_last) begin
         w_shift_next = r_shift >> 1;
      end

      w_tx_next = 1'b1;
      case (w_state_next)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

   // Bit-time counter, bit index, shift register and tx line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         if (w_in_bit_state) begin
            r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
         end else begin
            r_bit_cnt <= '0;
         end

         if (r_state == S_DATA) begin
            if (w_bit_last) begin
               r_bit_idx <= w_idx_last ? '0 : r_bit_idx + 1'b1;
            end
         end else begin
            r_bit_idx <= '0;
         end

         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
      end
   end

   assign fifo.fifo_rd_en = w_rd_en;
   assign busy            = w_busy;
   assign frame_done      = w_frame_done;
   assign tx              = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_fifo_serial_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_fifo_serial_tx
// Brief    : Directed self-checking bench for fifo_serial_tx, with one
//            default instance (BIT_CYCLES=4) and one BIT_CYCLES=1 instance.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fifo_serial_tx;

   logic clk = 1'b0;
   logic rst;
   logic en;

   int n_cmp = 0;
   int n_err = 0;
   int rd_empty_viol = 0;

   // DUT 0: default timing
   fifo_serial_tx_if #(.DATA_WIDTH(8)) if0 ();
   logic tx0, busy0, done0;
   // DUT 1: one clock per bit
   fifo_serial_tx_if #(.DATA_WIDTH(8)) if1 ();
   logic tx1, busy1, done1;

   fifo_serial_tx #(.DATA_WIDTH(8), .BIT_CYCLES(4)) u_dut0 (
      .clk        (clk),
      .reset      (rst),
      .enable     (en),
      .fifo       (if0.master),
      .tx         (tx0),
      .busy       (busy0),
      .frame_done (done0)
   );

   fifo_serial_tx #(.DATA_WIDTH(8), .BIT_CYCLES(1)) u_dut1 (
      .clk        (clk),
      .reset      (rst),
      .enable     (en),
      .fifo       (if1.master),
      .tx         (tx1),
      .busy       (busy1),
      .frame_done (done1)
   );

   always #5 clk = ~clk;

   // Small FIFO models with registered data_out
   logic [7:0]  m0 [0:15];
   logic [7:0]  m1 [0:15];
   int unsigned wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

   assign if0.fifo_empty = (wp0 == rp0);
   assign if1.fifo_empty = (wp1 == rp1);

   initial begin
      if0.fifo_data = '0;
      if1.fifo_data = '0;
   end

   always @(posedge clk) begin
      if (if0.fifo_rd_en) begin
         if0.fifo_data <= m0[rp0[3:0]];
         rp0           <= rp0 + 1;
      end
      if (if1.fifo_rd_en) begin
         if1.fifo_data <= m1[rp1[3:0]];
         rp1           <= rp1 + 1;
      end
   end

   always @(negedge clk) begin
      if ((if0.fifo_rd_en && if0.fifo_empty) || (if1.fifo_rd_en && if1.fifo_empty))
         rd_empty_viol++;
   end

   // Per-cycle capture of DUT 0 relative to a POP cycle (index 0)
   logic txs [0:127];
   logic rds [0:127];
   logic dns [0:127];
   logic bsy [0:127];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] w);
      m0[wp0[3:0]] = w;
      wp0 = wp0 + 1;
   endtask

   task automatic push1(input logic [7:0] w);
      m1[wp1[3:0]] = w;
      wp1 = wp1 + 1;
   endtask

   task automatic wait_pop0(input string tag);
      int n = 0;
      while (!if0.fifo_rd_en && n < 50) begin
         tick();
         n++;
      end
      check_val(tag, 32'(if0.fifo_rd_en), 32'd1);
   endtask

   task automatic record(input int from, input int to);
      for (int k = from; k <= to; k++) begin
         if (k != 0) tick();
         txs[k] = tx0;
         rds[k] = if0.fifo_rd_en;
         dns[k] = done0;
         bsy[k] = busy0;
      end
   endtask

   // Frame bits sampled at the first cycle of each 4-cycle bit, bit0 = start
   function automatic logic [9:0] frame_at(input int base);
      logic [9:0] f;
      for (int b = 0; b < 10; b++) f[b] = txs[base + 2 + 4*b];
      return f;
   endfunction

   function automatic int hold_err(input int base);
      int e = 0;
      for (int b = 0; b < 10; b++)
         for (int j = 1; j < 4; j++)
            if (txs[base + 2 + 4*b + j] !== txs[base + 2 + 4*b]) e++;
      return e;
   endfunction

   function automatic int first_done(input int from, input int to);
      for (int k = from; k <= to; k++) if (dns[k]) return k;
      return -1;
   endfunction

   function automatic int first_rd(input int from, input int to);
      for (int k = from; k <= to; k++) if (rds[k]) return k;
      return -1;
   endfunction

   function automatic int count_idle(input int from, input int to);
      int c = 0;
      for (int k = from; k <= to; k++) if (!bsy[k]) c++;
      return c;
   endfunction

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int viol;
      int run;
      logic       t1 [0:15];
      logic       r1 [0:15];
      logic       d1 [0:15];
      logic [9:0] f1;
      int         k1;

      rst = 1'b1;
      en  = 1'b0;
      repeat (3) tick();
      check_val("rst_tx",   32'(tx0),            32'd1);
      check_val("rst_busy", 32'(busy0),          32'd0);
      check_val("rst_rd",   32'(if0.fifo_rd_en), 32'd0);
      check_val("rst_done", 32'(done0),          32'd0);

      // Idle with empty FIFO
      rst = 1'b0;
      en  = 1'b1;
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || if0.fifo_rd_en !== 1'b0 || done0 !== 1'b0)
            viol++;
      end
      check_val("idle_hold", 32'(viol), 32'd0);

      // Single word 0xA5
      push0(8'hA5);
      wait_pop0("a5_pop");
      record(0, 41);
      check_val("a5_frame",   32'(frame_at(0)),    32'({1'b1, 8'hA5, 1'b0}));
      check_val("a5_hold",    32'(hold_err(0)),    32'd0);
      check_val("a5_load_tx", 32'(txs[1]),         32'd1);
      check_val("a5_done_at", 32'(first_done(0, 41)), 32'd41);
      check_val("a5_rd_once", 32'(first_rd(1, 41)),   32'hFFFF_FFFF);
      check_val("a5_busy",    32'(count_idle(0, 41)), 32'd0);
      tick();
      check_val("a5_idle_busy", 32'(busy0), 32'd0);
      check_val("a5_idle_tx",   32'(tx0),   32'd1);

      // Back-to-back 0x00 then 0xFF
      push0(8'h00);
      push0(8'hFF);
      wait_pop0("b2b_pop");
      record(0, 83);
      check_val("b2b_period", 32'(first_rd(1, 83)), 32'd42);
      check_val("b2b_f0",     32'(frame_at(0)),     32'({1'b1, 8'h00, 1'b0}));
      check_val("b2b_f1",     32'(frame_at(42)),    32'({1'b1, 8'hFF, 1'b0}));
      check_val("b2b_hold",   32'(hold_err(0) + hold_err(42)), 32'd0);
      run = 0;
      for (int k = 43; k >= 30 && txs[k] === 1'b1; k--) run++;
      check_val("b2b_gap_hi", 32'(run), 32'd6);
      check_val("b2b_no_idle", 32'(count_idle(0, 83)), 32'd0);
      check_val("b2b_done2",   32'(first_done(42, 83)), 32'd83);

      // Enable dropped during DATA with words still queued
      tick();
      push0(8'h11);
      push0(8'h22);
      push0(8'h33);
      wait_pop0("en_pop");
      record(0, 10);
      en = 1'b0;
      record(11, 41);
      check_val("en_frame",   32'(frame_at(0)),       32'({1'b1, 8'h11, 1'b0}));
      check_val("en_done_at", 32'(first_done(0, 41)), 32'd41);
      viol = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (if0.fifo_rd_en) viol++;
      end
      check_val("en_no_pop", 32'(viol),  32'd0);
      check_val("en_idle",   32'(busy0), 32'd0);
      en = 1'b1;
      tick();
      check_val("en_resume_pop", 32'(if0.fifo_rd_en), 32'd1);

      // Reset in the 3rd data bit of the 0x22 frame
      record(0, 15);
      rst = 1'b1;
      #1;
      check_val("mid_rst_tx",   32'(tx0),   32'd1);
      check_val("mid_rst_busy", 32'(busy0), 32'd0);
      tick();
      rst = 1'b0;
      check_val("mid_rst_rd", 32'(if0.fifo_rd_en), 32'd0);
      wait_pop0("post_rst_pop");
      record(0, 41);
      check_val("post_rst_frame", 32'(frame_at(0)),       32'({1'b1, 8'h33, 1'b0}));
      check_val("post_rst_done",  32'(first_done(0, 41)), 32'd41);

      // BIT_CYCLES=1 instance, two words of 0x3C
      push1(8'h3C);
      push1(8'h3C);
      k1 = 0;
      while (!if1.fifo_rd_en && k1 < 50) begin
         tick();
         k1++;
      end
      check_val("bc1_pop", 32'(if1.fifo_rd_en), 32'd1);
      for (int k = 0; k <= 12; k++) begin
         if (k != 0) tick();
         t1[k] = tx1;
         r1[k] = if1.fifo_rd_en;
         d1[k] = done1;
      end
      for (int b = 0; b < 10; b++) f1[b] = t1[2 + b];
      check_val("bc1_frame", 32'(f1), 32'h278);
      k1 = -1;
      for (int k = 12; k >= 1; k--) if (r1[k]) k1 = k;
      check_val("bc1_period", 32'(k1), 32'd12);
      k1 = -1;
      for (int k = 11; k >= 1; k--) if (d1[k]) k1 = k;
      check_val("bc1_done_at", 32'(k1), 32'd11);
      repeat (15) tick();
      check_val("bc1_idle", 32'(busy1), 32'd0);

      check_val("rd_while_empty", 32'(rd_empty_viol), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Read-side consumer for the team FIFO: pops one word at a time from the FIFO read port and serializes it onto a single-wire line.
- Frame format: start bit (0), DATA_WIDTH data bits LSB-first, stop bit (1); each bit is held for BIT_CYCLES clocks.
- Sits between the FIFO's read interface (empty, data_out, Read_enable) and an off-block serial link. It is the only reader of that FIFO.

Parameters:
- DATA_WIDTH, 8: width of FIFO word and of the serial payload.
- BIT_CYCLES, 4: clocks per serial bit. Must be ≥1; the value 1 must work.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting new frames; sampled only when deciding to pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO registered data_out (valid the cycle after a pop).
- fifo_rd_en  out  1  FIFO Read_enable; one-cycle pulse per word.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high whenever state is not IDLE.
- frame_done  out  1  one-cycle pulse in the final cycle of STOP.

Behaviour:
- Reset (async, immediate): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, counters and shift register cleared. Reset mid-frame abandons the word; it is already popped and is lost by design.
- States:
  - IDLE: if enable && !fifo_empty, go to POP; else stay.
  - POP: fifo_rd_en=1 (Moore output, exactly one cycle); go to LOAD. The FIFO advances and updates data_out at the edge leaving POP.
  - LOAD: fifo_data is valid; it is captured into the shift register at the edge leaving LOAD; go to START.
  - START: tx=0 for BIT_CYCLES clocks; go to DATA.
  - DATA: tx=shift[0] for BIT_CYCLES clocks per bit; shift right after each bit; after DATA_WIDTH bits go to STOP.
  - STOP: tx=1 for BIT_CYCLES clocks; frame_done=1 in the last cycle. Next state is POP if enable && !fifo_empty (back-to-back), else IDLE.
- tx register: loads the value for the state being entered on the same edge. It is 1 in IDLE, POP, LOAD and STOP.
- Counters:
  - bit-time counter runs 0..BIT_CYCLES-1 and wraps;
  - bit index runs 0..DATA_WIDTH-1.
  - Both are sized with $clog2 and are at least 1 bit wide.
- Frame period (POP to POP, back-to-back): 2 + BIT_CYCLES*(DATA_WIDTH+2). Defaults give 42 cycles.
- Line timing: the stop level is effectively extended by the 2 cycles of POP/LOAD between back-to-back frames.
- enable and fifo_empty are ignored outside the IDLE decision and the STOP exit decision. Dropping enable mid-frame lets the current frame finish.
- fifo_rd_en is never asserted while fifo_empty=1, and never on two consecutive cycles.

Test Plan:
- Reset/idle: assert reset, release; hold enable=1, fifo_empty=1 for 20 cycles -> tx=1, busy=0, fifo_rd_en=0, frame_done=0 throughout.
- Single word: FIFO holds 0xA5, enable=1 ->
  - fifo_rd_en high 1 cycle;
  - then tx, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1;
  - frame_done pulses 41 cycles after the POP cycle;
  - busy returns low.
- Back-to-back: FIFO holds 0x00 then 0xFF ->
  - fifo_rd_en pulses exactly 42 cycles apart;
  - payloads are 8×0 and 8×1;
  - tx stays high for 6 cycles between the two frames;
  - no IDLE cycle occurs between frames.
- Enable gating: deassert enable during DATA of a frame with FIFO non-empty ->
  - the frame completes and frame_done pulses;
  - no further fifo_rd_en while enable=0;
  - re-asserting enable gives fifo_rd_en on the next cycle.
- Reset mid-frame: assert reset during the 3rd data bit ->
  - tx=1 and busy=0 in the same cycle, without waiting for a clock edge;
  - after release with FIFO non-empty, a fresh POP occurs and a complete frame follows.
- BIT_CYCLES=1 instance: word 0x3C ->
  - tx = 0,0,0,1,1,1,1,0,0,1 on consecutive cycles after LOAD;
  - POP-to-POP period 12 cycles.
